baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter NB_DIV, default 16, width of the integer divisor.
REQ-002 SHALL have parameter NB_FRAC, default 4, width of the fractional divisor.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, o_tick pulses per o_bit_tick (power of two, 2..256).
REQ-004 SHALL have parameter DEFAULT_DIV, default 163, integer divisor applied after reset.
REQ-005 SHALL have parameter DEFAULT_FRAC, default 0, fractional divisor applied after reset.
REQ-006 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_enable  input  1  run when 1, clear-and-hold when 0.
REQ-009 SHALL have port i_div  input  NB_DIV  requested integer divisor.
REQ-010 SHALL have port i_frac  input  NB_FRAC  requested fractional divisor, units of 1/2^NB_FRAC.
REQ-011 SHALL have port i_load  input  1  single-cycle request to capture i_div/i_frac.
REQ-012 SHALL have port o_load_ack  output  1  single-cycle pulse when a captured divisor becomes active.
REQ-013 SHALL have port o_tick  output  1  oversample tick, one cycle wide.
REQ-014 SHALL have port o_bit_tick  output  1  bit-rate tick, one cycle wide, coincident with every OVERSAMPLE-th o_tick.

Function
REQ-015 Period counter SHALL count 0..P-1, P = div_active + carry; o_tick (registered) SHALL be high for exactly the cycle in which counter equals P-1, counter then returns to 0.
REQ-016 Fractional accumulator (NB_FRAC bits) SHALL add frac_active on every o_tick; carry-out of that add SHALL set carry=1 for the next period only; average period = div_active + frac_active/2^NB_FRAC.
REQ-017 With i_enable first sampled high in cycle 0 (counter 0), first o_tick SHALL occur in cycle P-1.
REQ-018 Sub-counter SHALL count o_tick 0..OVERSAMPLE-1; o_bit_tick SHALL assert with the o_tick that moves it from OVERSAMPLE-1 to 0.
REQ-019 i_load SHALL copy i_div/i_frac into a pending shadow and set a pending flag; a second i_load before application SHALL overwrite the shadow (latest wins, one ack only).
REQ-020 Pending values SHALL become active on the o_tick cycle (next period uses them), or on the next cycle if i_enable is 0; o_load_ack SHALL pulse in that same cycle.
REQ-021 i_load coincident with an o_tick SHALL be applied at the following o_tick, not the current one.
REQ-022 On application, divisor values 0 and 1 SHALL saturate to 2; accumulator SHALL clear to 0.
REQ-023 i_enable low SHALL clear period counter, sub-counter, accumulator and carry, force o_tick/o_bit_tick to 0; active divisor and pending shadow SHALL be retained.
REQ-024 Counter width SHALL be NB_DIV+1 so P = 2^NB_DIV (max divisor plus carry) is representable without wrap.

Reset
REQ-025 i_reset_n low SHALL asynchronously set counter, sub-counter, accumulator, carry, pending flag to 0, div_active=DEFAULT_DIV (saturated per REQ-022), frac_active=DEFAULT_FRAC, o_tick=o_bit_tick=o_load_ack=0.
REQ-026 Reset deassertion mid-operation SHALL restart timing per REQ-017 with no residual pending load.

Configuration
REQ-027 Macro BAUD_GEN_FRAC_EN defined: fractional accumulator and carry present per REQ-016.
REQ-028 Macro BAUD_GEN_FRAC_EN undefined: accumulator omitted, carry tied 0, i_frac and DEFAULT_FRAC ignored, P = div_active always; port list unchanged.

Verification
REQ-029 DEFAULT_DIV=10, OVERSAMPLE=4, enable after reset -> first o_tick cycle 9, then every 10 cycles; o_bit_tick on every 4th o_tick (cycles 39, 79).
REQ-030 BAUD_GEN_FRAC_EN defined, NB_FRAC=4, div=10, frac=8 -> periods alternate 10,11 (first 10); undefined -> all periods 10.
REQ-031 Running div=10, i_load div=20 at counter=3 -> current period ends at 10 cycles with o_load_ack coincident with o_tick, next period 20.
REQ-032 i_load div=1 then i_load div=6 before next o_tick -> single o_load_ack, subsequent period 6; separately i_load div=1 alone -> period 2.
REQ-033 i_reset_n low for 1 cycle at counter=5 with pending load -> all outputs 0, pending dropped, next o_tick DEFAULT_DIV-1 cycles after deassertion.
REQ-034 i_enable low for 3 cycles mid-period -> no ticks while low, re-enable gives first o_tick P-1 cycles later, sub-counter restarted at 0.

Source files
------------

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with oversample and bit ticks
//
// Optional feature macro: BAUD_GEN_FRAC_EN (fractional accumulator present when defined).
//
// Ports:
//   i_clk       sole clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_enable    run when 1, clear-and-hold when 0
//   i_div       requested integer divisor
//   i_frac      requested fractional divisor, units of 1/2^NB_FRAC
//   i_load      capture i_div/i_frac into the pending shadow
//   o_load_ack  pulse in the cycle a captured divisor becomes active
//   o_tick      oversample tick, one cycle wide
//   o_bit_tick  bit-rate tick, coincident with every OVERSAMPLE-th o_tick
module baud_gen_frac #(
    parameter int NB_DIV       = 16,
    parameter int NB_FRAC      = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_DIV  = 163,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic [NB_DIV-1:0]  i_div,
    input  logic [NB_FRAC-1:0] i_frac,
    input  logic               i_load,
    output logic               o_load_ack,
    output logic               o_tick,
    output logic               o_bit_tick
);

    // One extra bit so a full-scale divisor plus carry does not wrap.
    localparam int NB_CNT = NB_DIV + 1;
    localparam int NB_SUB = $clog2(OVERSAMPLE);
    localparam logic [NB_SUB-1:0] SUB_LAST = NB_SUB'(OVERSAMPLE - 1);
    localparam logic [NB_DIV-1:0] DEF_DIV  = (DEFAULT_DIV < 2) ? NB_DIV'(2) : NB_DIV'(DEFAULT_DIV);

    // Divisors 0 and 1 cannot produce a one-cycle-wide tick with a gap; force 2.
    function automatic logic [NB_DIV-1:0] sat_div(input logic [NB_DIV-1:0] d);
        return (d[NB_DIV-1:1] == '0) ? NB_DIV'(2) : d;
    endfunction

    logic [NB_CNT-1:0] cnt_q, cnt_d, p_d;
    logic [NB_SUB-1:0] sub_q, sub_d;
    logic [NB_DIV-1:0] div_q, div_d, div_pend_q;
    logic              pend_q, pend_d;
    logic              apply;
    logic              carry_d;
    logic              tick_d, bit_tick_d, ack_d;

    // The pending divisor is swapped in at the end of a tick cycle, so the
    // next period already uses it; while idle it is swapped in immediately.
    // The registered pend_q (not i_load) is used, so a load arriving in the
    // tick cycle itself waits for the following tick.
    assign apply = pend_q && (o_tick || !i_enable);

    always_comb begin
        div_d  = apply ? sat_div(div_pend_q) : div_q;
        pend_d = i_load || (pend_q && !apply);
        cnt_d  = cnt_q;
        sub_d  = sub_q;
        if (!i_enable) begin
            cnt_d = '0;
            sub_d = '0;
        end else if (o_tick) begin
            cnt_d = '0;
            sub_d = sub_q + NB_SUB'(1);
        end else begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
        p_d = {1'b0, div_d} + {{NB_DIV{1'b0}}, carry_d};
        // Outputs are registered one edge ahead so they line up with the
        // cycle in which the counter sits at P-1.
        tick_d     = i_enable && (cnt_d == p_d - NB_CNT'(1));
        bit_tick_d = tick_d && (sub_d == SUB_LAST);
        // Running: acknowledge alongside the tick whose end applies the load.
        // Idle: acknowledge in the cycle right after the immediate swap.
        ack_d      = (tick_d && pend_d) || (apply && !o_tick);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            sub_q      <= '0;
            div_q      <= DEF_DIV;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            o_tick     <= 1'b0;
            o_bit_tick <= 1'b0;
            o_load_ack <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            o_tick     <= tick_d;
            o_bit_tick <= bit_tick_d;
            o_load_ack <= ack_d;
            if (i_load) begin
                div_pend_q <= i_div;
            end
        end
    end

`ifdef BAUD_GEN_FRAC_EN
    logic [NB_FRAC-1:0] frac_q, frac_pend_q, acc_q, acc_d;
    logic [NB_FRAC:0]   acc_sum;
    logic               carry_q;

    // Carry out of the accumulator stretches only the next period by one.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
        acc_d   = acc_q;
        carry_d = carry_q;
        if (!i_enable || apply) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (o_tick) begin
            acc_d   = acc_sum[NB_FRAC-1:0];
            carry_d = acc_sum[NB_FRAC];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frac_q      <= NB_FRAC'(DEFAULT_FRAC);
            frac_pend_q <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            if (apply) begin
                frac_q <= frac_pend_q;
            end
            if (i_load) begin
                frac_pend_q <= i_frac;
            end
        end
    end
`else
    logic unused_frac;

    assign carry_d     = 1'b0;
    assign unused_frac = ^{i_frac, NB_FRAC'(DEFAULT_FRAC)};
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic [15:0] i_div;
    logic [3:0]  i_frac;
    logic        i_load;
    logic        o_load_ack;
    logic        o_tick;
    logic        o_bit_tick;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;

    typedef struct packed {
        logic [15:0]     div;
        logic [3:0]      frac;
        logic [3:0][7:0] ef;  // first-tick latency then 3 periods, fractional build
        logic [3:0][7:0] ei;  // same, integer-only build
    } vec_t;

    vec_t vecs[$];

    baud_gen_frac #(
        .NB_DIV      (16),
        .NB_FRAC     (4),
        .OVERSAMPLE  (4),
        .DEFAULT_DIV (10),
        .DEFAULT_FRAC(0)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_div     (i_div),
        .i_frac    (i_frac),
        .i_load    (i_load),
        .o_load_ack(o_load_ack),
        .o_tick    (o_tick),
        .o_bit_tick(o_bit_tick)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_load_ack) ack_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_tick && n < 3000);
        if (!o_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no o_tick expected one within 3000 cycles");
        end
    endtask

    task automatic config_idle(input int d, input int f);
        i_enable = 1'b0;
        step();
        i_div  = 16'(d);
        i_frac = 4'(f);
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        chk("idle_ack_early", int'(o_load_ack), 0);
        step();
        chk("idle_ack", int'(o_load_ack), 1);
        step();
        chk("idle_ack_single", int'(o_load_ack), 0);
    endtask

    task automatic add_vec(input int d, input int f,
                           input int f0, input int f1, input int f2, input int f3,
                           input int n0, input int n1, input int n2, input int n3);
        vec_t v;
        v.div   = 16'(d);
        v.frac  = 4'(f);
        v.ef[0] = 8'(f0); v.ef[1] = 8'(f1); v.ef[2] = 8'(f2); v.ef[3] = 8'(f3);
        v.ei[0] = 8'(n0); v.ei[1] = 8'(n1); v.ei[2] = 8'(n2); v.ei[3] = 8'(n3);
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int a0;
        int exp_p;

        add_vec(10, 0,  9, 10, 10, 10,  9, 10, 10, 10);
        add_vec(10, 8,  9, 10, 11, 10,  9, 10, 10, 10);
        add_vec(0,  0,  1,  2,  2,  2,  1,  2,  2,  2);
        add_vec(1,  8,  1,  2,  3,  2,  1,  2,  2,  2);
        add_vec(2,  15, 1,  2,  3,  3,  1,  2,  2,  2);
        add_vec(3,  0,  2,  3,  3,  3,  2,  3,  3,  3);
        add_vec(7,  12, 6,  7,  8,  8,  6,  7,  7,  7);

        // reset state
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        i_load    = 1'b0;
        i_div     = '0;
        i_frac    = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_tick", int'(o_tick), 0);
        chk("rst_bit_tick", int'(o_bit_tick), 0);
        chk("rst_ack", int'(o_load_ack), 0);
        i_reset_n = 1'b1;
        step();

        // default divisor: first tick at cycle 9, bit ticks at 39 and 79
        i_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            chk($sformatf("def_period%0d", k), n, (k == 0) ? 9 : 10);
            chk($sformatf("def_bit%0d", k), int'(o_bit_tick), (k == 3 || k == 7) ? 1 : 0);
        end

        // table: divisor/fraction patterns loaded while idle
        foreach (vecs[i]) begin
            config_idle(int'(vecs[i].div), int'(vecs[i].frac));
            i_enable = 1'b1;
            for (int k = 0; k < 4; k++) begin
                wait_tick(n);
`ifdef BAUD_GEN_FRAC_EN
                exp_p = int'(vecs[i].ef[k]);
`else
                exp_p = int'(vecs[i].ei[k]);
`endif
                chk($sformatf("vec%0d_p%0d", i, k), n, exp_p);
            end
        end

        // load mid-period: current period unchanged, ack with the tick
        config_idle(10, 0);
        i_enable = 1'b1;
        wait_tick(n);
        repeat (4) step();
        i_div  = 16'd20;
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        wait_tick(n);
        chk("mid_load_cur_period", n + 5, 10);
        chk("mid_load_ack", int'(o_load_ack), 1);
        wait_tick(n);
        chk("mid_load_next_period", n, 20);
        chk("mid_load_no_reack", int'(o_load_ack), 0);

        // two loads before the tick: latest wins, single ack
        repeat (2) step();
        i_div  = 16'd1;
        i_load = 1'b1;
        step();
        i_div = 16'd6;
        step();
        i_load = 1'b0;
        a0 = ack_cnt;
        wait_tick(n);
        chk("dbl_load_ack", int'(o_load_ack), 1);
        wait_tick(n);
        chk("dbl_load_period", n, 6);
        chk("dbl_load_ack_count", ack_cnt - a0, 1);

        // divisor 1 alone saturates to 2
        step();
        i_div  = 16'd1;
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        wait_tick(n);
        wait_tick(n);
        chk("sat1_period_a", n, 2);
        wait_tick(n);
        chk("sat1_period_b", n, 2);

        // load coincident with a tick waits for the following tick
        i_div  = 16'd8;
        i_load = 1'b1;
        chk("coinc_no_ack", int'(o_load_ack), 0);
        step();
        i_load = 1'b0;
        wait_tick(n);
        chk("coinc_old_period", n + 1, 2);
        chk("coinc_ack", int'(o_load_ack), 1);
        wait_tick(n);
        chk("coinc_new_period", n, 8);

        // reset pulse mid-period with a load pending
        repeat (6) step();
        i_div  = 16'd30;
        i_load = 1'b1;
        step();
        i_load    = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("async_rst_outs", int'({o_tick, o_bit_tick, o_load_ack}), 0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        wait_tick(n);
        chk("post_rst_first", n, 9);
        chk("post_rst_no_ack", int'(o_load_ack), 0);
        wait_tick(n);
        chk("post_rst_period", n, 10);

        // enable low 3 cycles mid-period: no ticks, full restart
        repeat (3) step();
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold_tick%0d", k), int'({o_tick, o_bit_tick}), 0);
        end
        i_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            chk($sformatf("reen_period%0d", k), n, (k == 0) ? 9 : 10);
            chk($sformatf("reen_bit%0d", k), int'(o_bit_tick), (k == 3) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
